// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS32 memory-stage load/store unit with byte enables,
// load extension, alignment/opcode checks and bus-timeout abort.
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_badaddr,
  output logic        busy
);
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24,
                         LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, EXC} state_t;
  state_t      state;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic [7:0]  cnt;
  logic        legal, misaligned;
  logic [3:0]  we_n;
  logic [31:0] wd_n, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  always_comb begin
    legal      = req_opcode inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
    misaligned = (req_opcode inside {LH, LHU, SH}) ? req_addr[0] :
                 (req_opcode inside {LW, SW})      ? |req_addr[1:0] : 1'b0;
    we_n = req_opcode == SB ? 4'b0001 << req_addr[1:0] :
           req_opcode == SH ? (req_addr[1] ? 4'b1100 : 4'b0011) :
           req_opcode == SW ? 4'b1111 : 4'b0000;
    wd_n = req_opcode == SB ? {4{req_wdata[7:0]}} :
           req_opcode == SH ? {2{req_wdata[15:0]}} : req_wdata;
    ld_byte = mem_rdata[{addr[1:0], 3'b000} +: 8];
    ld_half = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data = op == LB  ? {{24{ld_byte[7]}}, ld_byte} :
              op == LBU ? {24'b0, ld_byte} :
              op == LH  ? {{16{ld_half[15]}}, ld_half} :
              op == LHU ? {16'b0, ld_half} : mem_rdata;
  end
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      op          <= '0;
      addr        <= '0;
      wdata       <= '0;
      rd          <= '0;
      cnt         <= '0;
      mem_en      <= 1'b0;
      mem_we      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      exc_valid   <= 1'b0;
      exc_code    <= '0;
      exc_badaddr <= '0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          op    <= req_opcode;
          addr  <= req_addr;
          wdata <= req_wdata;
          rd    <= req_rd;
          if (legal && !misaligned) begin
            state     <= ACCESS;
            cnt       <= '0;
            mem_en    <= 1'b1;
            mem_we    <= we_n;
            mem_addr  <= req_addr[31:2];
            mem_wdata <= wd_n;
          end else begin
            state       <= EXC;
            exc_valid   <= 1'b1;
            exc_code    <= !legal ? 2'b00 : req_opcode[3] ? 2'b10 : 2'b01;
            exc_badaddr <= req_addr;
          end
        end
        ACCESS: if (mem_ack) begin
          mem_en <= 1'b0;
          mem_we <= '0;
          state  <= op[3] ? IDLE : RESP;
          if (!op[3]) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd;
            wb_data  <= ld_data;
          end
        end else if (cnt == CNT_LAST) begin
          // Abort: the unit leaves ACCESS, so any later ack falls on a non-ACCESS state
          mem_en      <= 1'b0;
          mem_we      <= '0;
          state       <= EXC;
          exc_valid   <= 1'b1;
          exc_code    <= 2'b11;
          exc_badaddr <= addr;
        end else begin
          cnt <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;
  logic        CLK = 1'b0, reset = 1'b0;
  logic        req_valid = 1'b0, mem_ack = 1'b0;
  logic [5:0]  req_opcode = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = 32'hDDCCBB1A;
  logic [4:0]  req_rd = '0;
  logic        req_ready, mem_en, wb_valid, exc_valid, busy;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, wb_data, exc_badaddr;
  logic [4:0]  wb_rd;
  logic [1:0]  exc_code;
  int n_checks = 0, n_fail = 0;
  mem_access_unit #(.TIMEOUT(15)) dut (
    .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_badaddr(exc_badaddr),
    .busy(busy)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    @(negedge CLK);
    check("ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_opcode = op; req_addr = a; req_wdata = wd; req_rd = rd;
    @(posedge CLK);
    #1 req_valid = 1'b0;
  endtask
  task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [4:0] rd, input logic [31:0] exp);
    issue(op, a, 32'h0, rd);
    @(negedge CLK);
    check({tag, "_en"}, 32'(mem_en), 32'd1);
    check({tag, "_addr"}, 32'(mem_addr), 32'(a[31:2]));
    check({tag, "_we"}, 32'(mem_we), 32'h0);
    @(negedge CLK);
    mem_ack = 1'b1;
    @(negedge CLK);
    mem_ack = 1'b0;
    check({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    check({tag, "_data"}, wb_data, exp);
    check({tag, "_rd"}, 32'(wb_rd), 32'(rd));
    check({tag, "_excv"}, 32'(exc_valid), 32'd0);
    @(negedge CLK);
    check({tag, "_wbv_off"}, 32'(wb_valid), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask
  task automatic do_store(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we, input logic [31:0] wdo);
    issue(op, a, wd, 5'd7);
    @(negedge CLK);
    check({tag, "_en"}, 32'(mem_en), 32'd1);
    check({tag, "_we"}, 32'(mem_we), 32'(we));
    check({tag, "_wdata"}, mem_wdata, wdo);
    check({tag, "_addr"}, 32'(mem_addr), 32'(a[31:2]));
    @(negedge CLK);
    check({tag, "_we_hold"}, 32'(mem_we), 32'(we));
    mem_ack = 1'b1;
    @(negedge CLK);
    mem_ack = 1'b0;
    check({tag, "_wbv"}, 32'(wb_valid), 32'd0);
    check({tag, "_en_off"}, 32'(mem_en), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask
  task automatic do_exc(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [1:0] code);
    issue(op, a, 32'h0, 5'd3);
    @(negedge CLK);
    check({tag, "_excv"}, 32'(exc_valid), 32'd1);
    check({tag, "_code"}, 32'(exc_code), 32'(code));
    check({tag, "_bad"}, exc_badaddr, a);
    check({tag, "_en"}, 32'(mem_en), 32'd0);
    check({tag, "_wbv"}, 32'(wb_valid), 32'd0);
    @(negedge CLK);
    check({tag, "_excv_off"}, 32'(exc_valid), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_en2"}, 32'(mem_en), 32'd0);
  endtask
  initial begin
    int n;
    @(negedge CLK);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_en", 32'(mem_en), 32'd0);
    check("rst_wbdata", wb_data, 32'h0);
    check("rst_code", 32'(exc_code), 32'h0);
    @(negedge CLK);
    reset = 1'b1;
    do_load("lb10", 6'h20, 32'h10, 5'd1, 32'h0000001A);
    do_load("lb11", 6'h20, 32'h11, 5'd2, 32'hFFFFFFBB);
    do_load("lb12", 6'h20, 32'h12, 5'd3, 32'hFFFFFFCC);
    do_load("lb13", 6'h20, 32'h13, 5'd4, 32'hFFFFFFDD);
    do_load("lbu11", 6'h24, 32'h11, 5'd5, 32'h000000BB);
    do_load("lhu12", 6'h25, 32'h12, 5'd6, 32'h0000DDCC);
    do_load("lh12", 6'h21, 32'h12, 5'd31, 32'hFFFFDDCC);
    do_load("lw10", 6'h23, 32'h10, 5'd0, 32'hDDCCBB1A);
    do_store("sb13", 6'h28, 32'h13, 32'h123456EE, 4'b1000, 32'hEEEEEEEE);
    do_store("sh12", 6'h29, 32'h12, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);
    do_store("sw10", 6'h2B, 32'h10, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
    do_exc("lw12", 6'h23, 32'h12, 2'b01);
    do_exc("sh11", 6'h29, 32'h11, 2'b10);
    do_exc("op22", 6'h22, 32'h10, 2'b00);
    // ack withheld: count mem_en cycles, then exception; a late ack must be ignored
    issue(6'h23, 32'h10, 32'h0, 5'd9);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (mem_en) n++;
      else break;
    end
    check("to_len", 32'(n), 32'd15);
    check("to_excv", 32'(exc_valid), 32'd1);
    check("to_code", 32'(exc_code), 32'd3);
    check("to_bad", exc_badaddr, 32'h10);
    mem_ack = 1'b1;
    @(negedge CLK);
    check("to_late_wbv", 32'(wb_valid), 32'd0);
    check("to_excv_off", 32'(exc_valid), 32'd0);
    @(negedge CLK);
    check("to_late_wbv2", 32'(wb_valid), 32'd0);
    mem_ack = 1'b0;
    // async reset in the middle of an access with an ack pending
    issue(6'h20, 32'h11, 32'h0, 5'd2);
    @(negedge CLK);
    check("ar_en_before", 32'(mem_en), 32'd1);
    mem_ack = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("ar_en", 32'(mem_en), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_ready", 32'(req_ready), 32'd1);
    @(negedge CLK);
    mem_ack = 1'b0;
    check("ar_wbv", 32'(wb_valid), 32'd0);
    check("ar_excv", 32'(exc_valid), 32'd0);
    reset = 1'b1;
    do_load("ar_lb11", 6'h20, 32'h11, 5'd2, 32'hFFFFFFBB);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit for the MIPS32 core. It sits between the execute stage and the data memory. It accepts one load/store per handshake and drives a word-addressed data memory port with byte enables. It waits a variable number of cycles for the memory acknowledge, then returns the aligned and extended load result to register writeback. Misaligned accesses, unsupported opcodes and bus timeouts are reported as exceptions instead of being performed.

## Interface
- TIMEOUT, 15: maximum number of cycles `mem_en` may stay high without `mem_ack` before the access is aborted; range 1–255.
- CLK  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_opcode  in  6  MIPS primary opcode: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
- req_addr  in  32  byte address, already computed as base+offset.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  5  destination register for loads.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  byte write enables; lane i = `mem_wdata[8i+7:8i]`.
- mem_addr  out  30  word address, equal to `addr[31:2]`.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word; valid in the cycle `mem_ack` is high.
- mem_ack  in  1  access completes this cycle.
- wb_valid  out  1  one-cycle pulse carrying a load result.
- wb_rd  out  5  destination register.
- wb_data  out  32  extended load result.
- exc_valid  out  1  one-cycle exception pulse.
- exc_code  out  2  exception code: 00 unsupported opcode, 01 misaligned load, 10 misaligned store, 11 bus timeout.
- exc_badaddr  out  32  faulting byte address.
- busy  out  1  high whenever the unit is not in IDLE.

## Operation
- Byte order is little-endian: byte address A maps to lane A[1:0].
- States and transitions:
  - IDLE -> ACCESS on accept (`req_valid & req_ready`) when the opcode is legal and the address is aligned.
  - IDLE -> EXC on accept when the opcode is unsupported or the address is misaligned.
  - ACCESS -> RESP on `mem_ack` for a load.
  - ACCESS -> IDLE on `mem_ack` for a store.
  - ACCESS -> EXC when the timeout counter reaches TIMEOUT.
  - RESP -> IDLE and EXC -> IDLE unconditionally.
- On accept, register opcode, address, wdata and rd. The registered request is stable until the unit returns to IDLE.
- Alignment rules:
  - LH/LHU/SH require `addr[0]=0`.
  - LW/SW require `addr[1:0]=0`.
  - LB/LBU/SB are always aligned.
- ACCESS outputs: `mem_en=1`; `mem_addr`, `mem_we` and `mem_wdata` are held constant for the whole state.
- Write enables:
  - Loads: 0000.
  - SB: `4'b0001<<addr[1:0]`.
  - SH: 0011 if `addr[1]=0`, else 1100.
  - SW: 1111.
- Store data replication:
  - SB: `{4{wdata[7:0]}}`.
  - SH: `{2{wdata[15:0]}}`.
  - SW: wdata.
- Load extraction from `mem_rdata`, captured on the `mem_ack` edge:
  - LB/LBU: select lane `addr[1:0]`; LB sign-extends bit 7, LBU zero-fills.
  - LH/LHU: select half `addr[1]`; LH sign-extends bit 15, LHU zero-fills.
  - LW: the whole word.
- Timeout counter:
  - Cleared on entry to ACCESS.
  - Increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT, the unit drops `mem_en`, goes to EXC with code 11, and ignores any later ack.
- Loads with `rd=0` still pulse `wb_valid` with `wb_rd=0`; the register file discards the write.
- EXC state: `exc_valid=1` with code and badaddr. No memory access and no writeback for the faulting request.

## Timing
- Reset (asynchronous assert, synchronous deassert at the register level):
  - State IDLE.
  - All outputs 0 except `req_ready=1`.
  - `wb_data`, `wb_rd`, `exc_code` and `exc_badaddr` reset to 0.
  - Reset mid-access drops `mem_en` immediately; the pending request is lost and produces no writeback or exception.
- Accept at edge k:
  - `mem_en` is high from cycle k+1.
  - An ack sampled at edge m moves a load to RESP, so `wb_valid` is high in cycle m+1 only.
  - `req_ready` is high again in cycle m+2.
- Best-case load: 3 cycles from accept to next accept (ack in the first ACCESS cycle). Best-case store: 2 cycles.
- Exception path: `exc_valid` is high in cycle k+1; `req_ready` returns in cycle k+2.
- Timeout: `mem_en` is high for exactly TIMEOUT cycles, then `exc_valid` is high for 1 cycle.
- `req_valid` while busy is ignored; the execute stage must hold it until `req_ready`.
- `wb_valid` and `exc_valid` are never high in the same cycle.

## Test plan
- Memory word 0x10 = 0xDDCCBB1A, ack one cycle after `mem_en`:
  - LB 0x10 -> `wb_data` 0x0000001A.
  - LB 0x11 -> 0xFFFFFFBB.
  - LB 0x12 -> 0xFFFFFFCC.
  - LB 0x13 -> 0xFFFFFFDD.
  - Each with `mem_addr=0x4`, `mem_we=0000`.
- Same word:
  - LBU 0x11 -> 0x000000BB.
  - LHU 0x12 -> 0x0000DDCC.
  - LH 0x12 -> 0xFFFFDDCC.
  - LW 0x10 -> 0xDDCCBB1A.
  - `wb_rd` echoes `req_rd`.
- Stores:
  - SB 0x13, wdata 0x123456EE -> `mem_we=1000`, `mem_wdata=0xEEEEEEEE`.
  - SH 0x12, wdata 0x0000BEEF -> `mem_we=1100`, `mem_wdata=0xBEEFBEEF`.
  - All stores -> no `wb_valid`.
- Exception requests:
  - LW 0x12 -> `exc_valid` cycle k+1, code 01, badaddr 0x12, `mem_en` never high.
  - SH 0x11 -> code 10.
  - Opcode 0x22 -> code 00.
- Ack withheld:
  - With TIMEOUT=15, `mem_en` high for exactly 15 cycles, then code 11 with badaddr = request address.
  - A late ack afterwards produces no `wb_valid`.
- Async reset asserted mid-ACCESS with ack pending -> `mem_en`/`busy` fall without a clock edge, `req_ready=1`; after release a fresh LB 0x11 returns 0xFFFFFFBB.
